// File: rtl/pzbcm_selector_pkg.sv
// Shared selector encodings and width helpers used by the pzbcm mux/demux family.
package pzbcm_selector_pkg;

  typedef enum logic [1:0] {
    PZBCM_SELECTOR_BINARY,
    PZBCM_SELECTOR_PRIORITY,
    PZBCM_SELECTOR_ONEHOT
  } pzbcm_selector_type;

  // Width of a binary index over `entries` items; never zero so ports stay legal.
  function automatic int calc_binary_index_width(int entries);
    return (entries >= 2) ? $clog2(entries) : 1;
  endfunction

  // Width of a select vector in the given encoding.
  function automatic int calc_select_width(pzbcm_selector_type selector_type, int entries);
    return (selector_type == PZBCM_SELECTOR_BINARY) ? calc_binary_index_width(entries) : entries;
  endfunction

endpackage

// File: rtl/pzbcm_stream_arbiter_pkg.sv
// Types and helpers for the round-robin stream arbiter.
package pzbcm_stream_arbiter_pkg;
  import pzbcm_selector_pkg::*;

  // Upper bound on ENTRIES supported by encode_grant's fixed-width vectors.
  localparam int PZBCM_STREAM_ARBITER_MAX_ENTRIES = 64;

  typedef logic [PZBCM_STREAM_ARBITER_MAX_ENTRIES-1:0] pzbcm_stream_arbiter_vector;

  typedef enum logic {
    ARBITRATE,
    LOCKED
  } pzbcm_stream_arbiter_state;

  // Convert a onehot winner into the select vector of the requested encoding.
  // PRIORITY and ONEHOT both carry the onehot vector unchanged; BINARY ORs the
  // indices of the set bits, which is exact because at most one bit is set.
  function automatic pzbcm_stream_arbiter_vector encode_grant(
    pzbcm_selector_type         selector_type,
    pzbcm_stream_arbiter_vector onehot
  );
    pzbcm_stream_arbiter_vector select;
    select = '0;
    if (selector_type == PZBCM_SELECTOR_BINARY) begin
      for (int i = 0; i < PZBCM_STREAM_ARBITER_MAX_ENTRIES; i++) begin
        if (onehot[i]) begin
          select = select | pzbcm_stream_arbiter_vector'(i);
        end
      end
    end else begin
      select = onehot;
    end
    return select;
  endfunction

endpackage

// File: rtl/pzbcm_rr_pointer_search.sv
// Combinational round-robin search: first request at or after the pointer,
// wrapping to the lowest request when none is at or above it.
module pzbcm_rr_pointer_search
  import pzbcm_selector_pkg::*;
#(
  parameter int  ENTRIES = 2,
  localparam int PTR_W   = calc_binary_index_width(ENTRIES)
)(
  input  logic [ENTRIES-1:0] i_request,
  input  logic [PTR_W-1:0]   i_pointer,
  output logic [ENTRIES-1:0] o_grant
);

  logic [ENTRIES-1:0] upper_mask;
  logic [ENTRIES-1:0] upper_request;
  logic [ENTRIES-1:0] search_request;

  // Requests at or above the pointer take precedence; otherwise fall back to
  // the full request vector, which is the wrapped half of a doubled vector.
  assign upper_mask     = {ENTRIES{1'b1}} << i_pointer;
  assign upper_request  = i_request & upper_mask;
  assign search_request = (|upper_request) ? upper_request : i_request;

  // Isolate the lowest set bit with a single carry chain.
  assign o_grant = search_request & (~search_request + ENTRIES'(1));

endmodule

// File: rtl/pzbcm_selector.sv
// Generic N-to-1 value selector driven by a binary, priority or onehot select.
module pzbcm_selector
  import pzbcm_selector_pkg::*;
#(
  parameter pzbcm_selector_type SELECTOR_TYPE = PZBCM_SELECTOR_BINARY,
  parameter int                 ENTRIES       = 2,
  parameter type                TYPE          = logic,
  localparam int                SELECT_WIDTH  = calc_select_width(SELECTOR_TYPE, ENTRIES)
)(
  input  logic [SELECT_WIDTH-1:0] i_select,
  input  TYPE                     i_value[ENTRIES],
  output TYPE                     o_value
);

  localparam int W = $bits(TYPE);

  if (SELECTOR_TYPE == PZBCM_SELECTOR_BINARY) begin : g_binary
    // Index select; out-of-range indices yield zero.
    always_comb begin
      logic [W-1:0] acc;
      // NOTE: every combinational variable gets a default first, otherwise a
      // path that skips the assignment infers a latch.
      acc = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        if (i_select == SELECT_WIDTH'(i)) begin
          acc = i_value[i];
        end
      end
      o_value = TYPE'(acc);
    end
  end else if (SELECTOR_TYPE == PZBCM_SELECTOR_PRIORITY) begin : g_priority
    // Lowest set select bit wins; walk downward so the lowest index overrides.
    always_comb begin
      logic [W-1:0] acc;
      acc = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (i_select[i]) begin
          acc = i_value[i];
        end
      end
      o_value = TYPE'(acc);
    end
  end else begin : g_onehot
    // AND-OR mux; caller guarantees at most one select bit is set.
    always_comb begin
      logic [W-1:0] acc;
      acc = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        acc = acc | ({W{i_select[i]}} & i_value[i]);
      end
      o_value = TYPE'(acc);
    end
  end

endmodule

// File: rtl/pzbcm_stream_arbiter.sv
// N-to-1 round-robin stream arbiter with packet locking and a registered
// output stage; the grant is emitted in pzbcm_selector select format.
module pzbcm_stream_arbiter
  import pzbcm_selector_pkg::*;
  import pzbcm_stream_arbiter_pkg::*;
#(
  parameter int                 ENTRIES      = 2,
  parameter int                 WIDTH        = 8,
  parameter type                TYPE         = logic [WIDTH-1:0],
  parameter pzbcm_selector_type GRANT_TYPE   = PZBCM_SELECTOR_BINARY,
  parameter TYPE                DEFAULT      = TYPE'(0),
  localparam int                SELECT_WIDTH = calc_select_width(GRANT_TYPE, ENTRIES)
)(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ENTRIES-1:0]      i_valid,
  output logic [ENTRIES-1:0]      o_ready,
  input  TYPE                     i_data[ENTRIES],
  input  logic [ENTRIES-1:0]      i_last,
  output logic                    o_valid,
  input  logic                    i_ready,
  output TYPE                     o_data,
  output logic                    o_last,
  output logic [SELECT_WIDTH-1:0] o_grant
);

  localparam int PTR_W = calc_binary_index_width(ENTRIES);

  pzbcm_stream_arbiter_state state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [PTR_W-1:0]          lock_q, lock_d;

  logic                      valid_q;
  TYPE                       data_q;
  logic                      last_q;
  logic [SELECT_WIDTH-1:0]   grant_q;

  logic                      load;
  logic [ENTRIES-1:0]        lock_onehot;
  logic [ENTRIES-1:0]        request;
  logic [ENTRIES-1:0]        winner;
  logic                      any_request;
  logic [PTR_W-1:0]          winner_index;
  logic [PTR_W-1:0]          next_ptr;
  logic                      winner_last;
  TYPE                       winner_data;
  logic [SELECT_WIDTH-1:0]   winner_grant;

  // The output register can take a beat when empty or being drained.
  assign load        = ~valid_q | i_ready;
  assign lock_onehot = ENTRIES'(1) << lock_q;

  // Candidate mask: every valid requester while arbitrating, only the locked
  // source while a packet is in flight.
  always_comb begin
    request = i_valid;
    if (state_q == LOCKED) begin
      request = i_valid & lock_onehot;
    end
  end

  pzbcm_rr_pointer_search #(
    .ENTRIES (ENTRIES)
  ) u_search (
    .i_request (request),
    .i_pointer (ptr_q),
    .o_grant   (winner)
  );

  pzbcm_selector #(
    .SELECTOR_TYPE (PZBCM_SELECTOR_ONEHOT),
    .ENTRIES       (ENTRIES),
    .TYPE          (TYPE)
  ) u_data_selector (
    .i_select (winner),
    .i_value  (i_data),
    .o_value  (winner_data)
  );

  assign any_request  = |request;
  assign winner_last  = |(winner & i_last);
  assign winner_index = PTR_W'(encode_grant(PZBCM_SELECTOR_BINARY,
                                            pzbcm_stream_arbiter_vector'(winner)));
  assign winner_grant = SELECT_WIDTH'(encode_grant(GRANT_TYPE,
                                                   pzbcm_stream_arbiter_vector'(winner)));
  assign next_ptr     = (winner_index == PTR_W'(ENTRIES - 1)) ? '0
                                                              : winner_index + PTR_W'(1);

  // Only the winner is accepted, and nothing is accepted during reset.
  assign o_ready = (load && !i_rst) ? winner : '0;

  // Arbitration state, round-robin pointer and lock index.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ARBITRATE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

  // Next state: a beat without last locks its source, a beat with last
  // releases the lock and advances the pointer past the winner.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    if (load && any_request) begin
      if (winner_last) begin
        ptr_d   = next_ptr;
        state_d = ARBITRATE;
      end else begin
        lock_d  = winner_index;
        state_d = LOCKED;
      end
    end
  end

  // Output register: load the winner, go idle with no candidate, hold on stall.
  // The grant keeps its last value when idle so downstream routing is stable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= DEFAULT;
      last_q  <= 1'b0;
      grant_q <= '0;
    end else if (load) begin
      if (any_request) begin
        valid_q <= 1'b1;
        data_q  <= winner_data;
        last_q  <= winner_last;
        grant_q <= winner_grant;
      end else begin
        valid_q <= 1'b0;
        data_q  <= DEFAULT;
        last_q  <= 1'b0;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_last  = last_q;
  assign o_grant = grant_q;

endmodule

// File: tb/tb_pzbcm_stream_arbiter.sv
// Directed bench for pzbcm_stream_arbiter: a BINARY-grant and a ONEHOT-grant
// instance with ENTRIES=4 share one stimulus stream.
module tb_pzbcm_stream_arbiter;
  import pzbcm_selector_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] valid;
  logic [N-1:0] last;
  logic [7:0]   data[N];
  logic         ready;

  logic [N-1:0] ready_b, ready_o;
  logic         ovalid_b, ovalid_o;
  logic [7:0]   odata_b, odata_o;
  logic         olast_b, olast_o;
  logic [1:0]   grant_b;
  logic [3:0]   grant_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pzbcm_stream_arbiter #(
    .ENTRIES    (N),
    .WIDTH      (8),
    .GRANT_TYPE (PZBCM_SELECTOR_BINARY)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (ready_b),
    .i_data  (data),
    .i_last  (last),
    .o_valid (ovalid_b),
    .i_ready (ready),
    .o_data  (odata_b),
    .o_last  (olast_b),
    .o_grant (grant_b)
  );

  pzbcm_stream_arbiter #(
    .ENTRIES    (N),
    .WIDTH      (8),
    .GRANT_TYPE (PZBCM_SELECTOR_ONEHOT)
  ) dut_oh (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .o_ready (ready_o),
    .i_data  (data),
    .i_last  (last),
    .o_valid (ovalid_o),
    .i_ready (ready),
    .o_data  (odata_o),
    .o_last  (olast_o),
    .o_grant (grant_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Mid-cycle point: combinational o_ready reflects the current inputs.
  task automatic at_neg();
    @(negedge clk);
  endtask

  // Just after the active edge: registered outputs hold the captured beat.
  task automatic at_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [1:0] g, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, 32'(ovalid_b), 32'd1);
    check({tag, "_grant"}, 32'(grant_b), 32'(g));
    check({tag, "_data"},  32'(odata_b), 32'(d));
    check({tag, "_last"},  32'(olast_b), 32'(l));
  endtask

  initial begin
    rst   = 1'b1;
    valid = 4'b1111;
    last  = 4'b1111;
    ready = 1'b1;
    for (int i = 0; i < N; i++) data[i] = 8'hA0 + 8'(i);

    // Reset held with every requester valid.
    at_pos();
    at_pos();
    check("rst_valid",   32'(ovalid_b), 32'd0);
    check("rst_ready",   32'(ready_b),  32'd0);
    check("rst_ready_oh", 32'(ready_o), 32'd0);
    check("rst_grant",   32'(grant_b),  32'd0);
    check("rst_grant_oh", 32'(grant_o), 32'd0);
    check("rst_data",    32'(odata_b),  32'd0);

    // Round-robin, one beat per cycle: grants 0,1,2,3,0.
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("rr_ready", 32'(ready_b), 32'(4'b0001 << (k % 4)));
      at_pos();
      check_beat("rr", 2'(k % 4), 8'hA0 + 8'(k % 4), 1'b1);
      check("rr_grant_oh", 32'(grant_o), 32'(4'b0001 << (k % 4)));
    end

    // Lock: pointer is 1; entry 1 sends 3 beats while 0 and 2 stay valid.
    valid   = 4'b0111;
    last    = 4'b1101;
    data[0] = 8'hC0;
    data[2] = 8'hC2;
    for (int b = 1; b <= 3; b++) begin
      last[1] = (b == 3);
      data[1] = 8'hB0 + 8'(b);
      at_neg();
      check("lock_ready", 32'(ready_b), 32'h2);
      at_pos();
      check_beat("lock", 2'd1, 8'hB0 + 8'(b), (b == 3));
    end
    valid = 4'b0101;
    at_neg();
    check("lock_after_ready", 32'(ready_b), 32'h4);
    at_pos();
    check_beat("lock_after2", 2'd2, 8'hC2, 1'b1);
    at_neg();
    check("lock_wrap_ready", 32'(ready_b), 32'h1);
    at_pos();
    check_beat("lock_after0", 2'd0, 8'hC0, 1'b1);

    // Backpressure: pointer is 1; beat from entry 1 then 5 stalled cycles.
    valid = 4'b1111;
    last  = 4'b1111;
    for (int i = 0; i < N; i++) data[i] = 8'hD0 + 8'(i);
    at_neg();
    check("bp_ready_first", 32'(ready_b), 32'h2);
    at_pos();
    check_beat("bp_first", 2'd1, 8'hD1, 1'b1);
    ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      at_neg();
      check("bp_stall_ready", 32'(ready_b), 32'd0);
      at_pos();
      check_beat("bp_stall", 2'd1, 8'hD1, 1'b1);
    end
    ready = 1'b1;
    at_neg();
    check("bp_release_ready", 32'(ready_b), 32'h4);
    at_pos();
    check_beat("bp_next", 2'd2, 8'hD2, 1'b1);

    // Wrap/sparse: pointer is 3, only entry 1 valid.
    valid   = 4'b0010;
    data[1] = 8'hE1;
    at_neg();
    check("sparse_ready", 32'(ready_b), 32'h2);
    at_pos();
    check_beat("sparse", 2'd1, 8'hE1, 1'b1);
    check("sparse_grant_oh", 32'(grant_o), 32'h2);
    // Pointer should now be 2.
    valid   = 4'b1111;
    data[1] = 8'hD1;
    at_neg();
    check("sparse_ptr_ready", 32'(ready_b), 32'h4);
    at_pos();
    check_beat("sparse_ptr", 2'd2, 8'hD2, 1'b1);

    // Idle: no candidate empties the register, grant holds.
    valid = 4'b0000;
    at_neg();
    check("idle_ready", 32'(ready_b), 32'd0);
    at_pos();
    check("idle_valid", 32'(ovalid_b), 32'd0);
    check("idle_data",  32'(odata_b),  32'd0);
    check("idle_last",  32'(olast_b),  32'd0);
    check("idle_grant", 32'(grant_b),  32'd2);

    // Reset mid-packet: lock on entry 2 (pointer 3 wraps to 2).
    valid   = 4'b0100;
    last    = 4'b0000;
    data[2] = 8'hF2;
    at_neg();
    check("mid_ready", 32'(ready_b), 32'h4);
    at_pos();
    check_beat("mid_first", 2'd2, 8'hF2, 1'b0);
    valid = 4'b0101;
    at_neg();
    check("mid_locked_ready", 32'(ready_b), 32'h4);
    at_pos();
    check_beat("mid_second", 2'd2, 8'hF2, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_valid",    32'(ovalid_b), 32'd0);
    check("mid_rst_ready",    32'(ready_b),  32'd0);
    check("mid_rst_grant",    32'(grant_b),  32'd0);
    check("mid_rst_grant_oh", 32'(grant_o),  32'd0);
    at_pos();
    rst  = 1'b0;
    last = 4'b1111;
    at_neg();
    check("post_rst_ready", 32'(ready_b), 32'h1);
    at_pos();
    check_beat("post_rst", 2'd0, 8'hD0, 1'b1);
    check("post_rst_grant_oh", 32'(grant_o), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
